// File: rtl/payload_engine_ctrl.sv
// Packet sequencer for the payload-engine array: clears engines per packet, feeds
// accepted bytes one per eng_en, waits for the engine pipeline, then reports one match vector.
module payload_engine_ctrl #(
    parameter int NUM_ENG   = 8,
    parameter int MAX_LEN   = 1500,
    parameter int LEN_W     = 11,
    parameter int FLUSH_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_sop,
    input  logic               s_eop,
    output logic               s_ready,
    output logic [7:0]         eng_byte,
    output logic               eng_sod,
    output logic               eng_en,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic [NUM_ENG-1:0] res_match,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_trunc,
    output logic               res_valid,
    input  logic               res_ready
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    localparam logic [LEN_W-1:0] MAX_LEN_L   = LEN_W'(MAX_LEN);
    localparam logic [3:0]       FLUSH_CYC_L = 4'(FLUSH_CYC);

    logic [2:0]         state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               trunc_q, trunc_d;
    logic [3:0]         flush_q, flush_d;
    logic [7:0]         eng_byte_q, eng_byte_d;
    logic               eng_en_q, eng_en_d;
    logic [NUM_ENG-1:0] res_match_q, res_match_d;
    logic [LEN_W-1:0]   res_len_q, res_len_d;
    logic               res_trunc_q, res_trunc_d;
    logic               res_valid_q, res_valid_d;
    logic               ready_c;
    logic               accept_c;
    logic               room_c;

    // In IDLE, non-sop beats are swallowed so stray data never reaches the engines.
    always_comb begin
        ready_c = 1'b0;
        if (state_q == S_STREAM) begin
            ready_c = 1'b1;
        end else if (state_q == S_IDLE) begin
            ready_c = s_valid & ~s_sop;
        end
    end

    assign accept_c = s_valid & ready_c;
    assign room_c   = (len_q < MAX_LEN_L);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        trunc_d     = trunc_q;
        flush_d     = flush_q;
        eng_byte_d  = eng_byte_q;
        eng_en_d    = 1'b0;
        res_match_d = res_match_q;
        res_len_d   = res_len_q;
        res_trunc_d = res_trunc_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (s_valid && s_sop) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                len_d   = '0;
                trunc_d = 1'b0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (accept_c) begin
                    if (room_c) begin
                        eng_byte_d = s_data;
                        eng_en_d   = 1'b1;
                        len_d      = len_q + 1'b1;
                    end else begin
                        trunc_d = 1'b1;
                    end
                    // A fed eop byte spends one extra FLUSH cycle while its eng_en is out.
                    if (s_eop) begin
                        state_d = S_FLUSH;
                        flush_d = room_c ? 4'd0 : 4'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_CYC_L) begin
                    res_match_d = eng_match;
                    res_len_d   = len_q;
                    res_trunc_d = trunc_q;
                    res_valid_d = 1'b1;
                    state_d     = S_REPORT;
                end else begin
                    flush_d = flush_q + 4'd1;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            flush_q     <= 4'd0;
            eng_byte_q  <= 8'd0;
            eng_en_q    <= 1'b0;
            res_match_q <= '0;
            res_len_q   <= '0;
            res_trunc_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            trunc_q     <= trunc_d;
            flush_q     <= flush_d;
            eng_byte_q  <= eng_byte_d;
            eng_en_q    <= eng_en_d;
            res_match_q <= res_match_d;
            res_len_q   <= res_len_d;
            res_trunc_q <= res_trunc_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign s_ready   = ready_c;
    assign eng_sod   = (state_q == S_CLEAR);
    assign eng_byte  = eng_byte_q;
    assign eng_en    = eng_en_q;
    assign res_match = res_match_q;
    assign res_len   = res_len_q;
    assign res_trunc = res_trunc_q;
    assign res_valid = res_valid_q;

endmodule
